// File: rtl/req_arbiter8.sv
// req_arbiter8: eight-way arbiter for one shared resource.
// Fixed or round-robin priority, registered grant, bounded hold time.
module req_arbiter8 #(
    parameter int MAX_HOLD = 16,
    parameter int HOLD_W   = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] req,
    input  logic       rr_en,
    output logic [7:0] gnt,
    output logic [2:0] gnt_idx,
    output logic       gnt_valid,
    output logic       timeout
);

    typedef enum logic {IDLE, GRANT} state_t;

    // Counter holds (cycles held - 1) so MAX_HOLD = 2^HOLD_W still fits.
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);

    state_t      state_q, state_d;
    logic [7:0]  gnt_q, gnt_d;
    logic [2:0]  idx_q, idx_d;
    logic        valid_q, valid_d;
    logic        timeout_q, timeout_d;
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic [2:0]  last_q, last_d;
    logic [7:0]  skip_q, skip_d;

    logic [7:0]  cand_raw;
    logic [7:0]  cand;
    logic [2:0]  win;
    logic        owner_req;
    logic        at_limit;

    // Rotate so that bit 'base' lands at position 0, then take the highest set bit.
    function automatic logic [2:0] pick(input logic [7:0] c, input logic [2:0] base);
        logic [15:0] dbl;
        logic [7:0]  rot;
        logic [2:0]  k;
        dbl = {c, c} >> base;
        rot = dbl[7:0];
        k   = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (rot[i]) begin
                k = 3'(i);
            end
        end
        return base + k;
    endfunction

    assign cand_raw  = req & ~skip_q;
    assign cand      = (|cand_raw) ? cand_raw : req;
    assign win       = pick(cand, rr_en ? last_q : 3'd0);
    assign owner_req = req[idx_q];
    assign at_limit  = (hold_q == HOLD_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (|cand) begin
                    state_d = GRANT;
                end
            end
            GRANT: begin
                if (!owner_req || at_limit) begin
                    state_d = IDLE;
                end
            end
        endcase
    end

    always_comb begin
        gnt_d     = gnt_q;
        idx_d     = idx_q;
        valid_d   = valid_q;
        timeout_d = 1'b0;
        hold_d    = hold_q;
        last_d    = last_q;
        skip_d    = skip_q;
        unique case (state_q)
            IDLE: begin
                skip_d  = 8'h00;
                hold_d  = '0;
                gnt_d   = 8'h00;
                idx_d   = 3'd0;
                valid_d = 1'b0;
                if (|cand) begin
                    gnt_d   = 8'd1 << win;
                    idx_d   = win;
                    valid_d = 1'b1;
                    last_d  = win;
                end
            end
            GRANT: begin
                if (!owner_req) begin
                    gnt_d   = 8'h00;
                    idx_d   = 3'd0;
                    valid_d = 1'b0;
                    skip_d  = 8'h00;
                end else if (at_limit) begin
                    // Skip the evicted owner once so a waiting peer gets a turn.
                    gnt_d     = 8'h00;
                    idx_d     = 3'd0;
                    valid_d   = 1'b0;
                    timeout_d = 1'b1;
                    skip_d    = gnt_q;
                end else begin
                    hold_d = hold_q + 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            gnt_q     <= 8'h00;
            idx_q     <= 3'd0;
            valid_q   <= 1'b0;
            timeout_q <= 1'b0;
            hold_q    <= '0;
            last_q    <= 3'd0;
            skip_q    <= 8'h00;
        end else begin
            gnt_q     <= gnt_d;
            idx_q     <= idx_d;
            valid_q   <= valid_d;
            timeout_q <= timeout_d;
            hold_q    <= hold_d;
            last_q    <= last_d;
            skip_q    <= skip_d;
        end
    end

    assign gnt       = gnt_q;
    assign gnt_idx   = idx_q;
    assign gnt_valid = valid_q;
    assign timeout   = timeout_q;

endmodule

// File: doc/req_arbiter8.md
Name: req_arbiter8

Overview:
- Eight-requester arbiter for one shared resource.
- Selects a winner with a priority-encoder search over the request vector; highest index wins in fixed mode.
- Optional round-robin mode rotates the priority so no requester starves.
- Holds a registered one-hot grant and a 3-bit grant index until the owner releases or the hold limit expires.
- Sits between the requesting blocks and the shared datapath/bus they contend for.

Parameters:
- MAX_HOLD, 16, maximum consecutive cycles one owner may hold the grant (legal range 2..256).
- HOLD_W, 8, width of the hold counter; must satisfy 2^HOLD_W >= MAX_HOLD.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- req  input  8  request vector; bit i = requester i wants the resource; level-sensitive.
- rr_en  input  1  1 = round-robin priority, 0 = fixed priority (bit 7 highest); sampled only in IDLE.
- gnt  output  8  one-hot grant; all zero when no owner.
- gnt_idx  output  3  binary index of the owner; 0 when gnt_valid = 0.
- gnt_valid  output  1  high while any grant is held.
- timeout  output  1  one-cycle pulse on the cycle the grant is removed due to the MAX_HOLD limit.

Behaviour:
- Reset (rst = 1 at a clock edge) forces:
  - gnt = 8'h00, gnt_idx = 3'd0, gnt_valid = 0, timeout = 0.
  - state = IDLE, hold_cnt = 0, last_idx = 3'd0, skip_mask = 8'h00.
- Reset takes priority over everything, including mid-grant.
- FSM has two states: IDLE and GRANT. All outputs are registered.
- IDLE:
  - Candidate vector: cand = req & ~skip_mask. If cand is zero but req is nonzero, use cand = req.
  - If cand is nonzero, the winner is loaded at this edge. Next cycle: state = GRANT, gnt = one-hot(winner), gnt_idx = winner, gnt_valid = 1, hold_cnt = 1, last_idx = winner.
  - Request-to-grant latency is 1 cycle.
  - skip_mask is cleared on every edge in IDLE.
- Fixed mode: winner = highest set index of cand (8'b1xxxxxxx -> 7, 8'b01xxxxxx -> 6, ... 8'b00000001 -> 0).
- Round-robin mode:
  - Search order is last_idx-1, last_idx-2, ... wrapping 0 -> 7, ending at last_idx (lowest priority).
  - After reset (last_idx = 0) the order is 7..0, identical to fixed mode.
- GRANT:
  - If req[gnt_idx] = 0: release. Next cycle: gnt = 0, gnt_valid = 0, gnt_idx = 0, state = IDLE, skip_mask = 0.
  - Else if hold_cnt == MAX_HOLD: forced release. Next cycle: gnt cleared, timeout = 1 for one cycle, state = IDLE, skip_mask = one-hot(old owner).
  - Else: hold, hold_cnt++.
  - Other requests never affect GRANT.
  - Owner holds at most MAX_HOLD cycles of gnt_valid.
- Exactly one dead cycle (gnt_valid = 0) always separates consecutive grants, including to the same requester.
- Simultaneous owner release and hold-limit hit: treated as a normal release, no timeout pulse.
- rr_en changes while in GRANT take effect at the next IDLE arbitration.
- Invariants:
  - gnt is always zero or one-hot.
  - gnt == (gnt_valid ? 1 << gnt_idx : 0).

Test Plan:
- Reset/idle: rst high 2 cycles, req = 8'h00 -> gnt = 8'h00, gnt_idx = 0, gnt_valid = 0, timeout = 0. Req = 8'h00 held 10 cycles -> outputs stay zero.
- Fixed priority: rr_en = 0, req = 8'h2C -> next cycle gnt = 8'h20, gnt_idx = 5. Drop req[5] -> 1 dead cycle, then gnt = 8'h08, idx 3. Drop bit 3 -> dead cycle, then idx 2.
- Round-robin: rr_en = 1, req = 8'hFF; each owner drops its req for 1 cycle after 2 cycles of grant, then re-raises -> grant sequence idx 7,6,5,4,3,2,1,0,7 with one dead cycle between each.
- Hold limit: MAX_HOLD = 4, rr_en = 0, req = 8'h81 held:
  - gnt = 8'h80 for exactly 4 cycles, then timeout = 1 with gnt = 0.
  - Next grant is 8'h01 (bit 7 skipped once), then after its 4 cycles back to 8'h80.
- Single requester timeout: MAX_HOLD = 4, req = 8'h10 held -> gnt 8'h10 for 4 cycles, timeout pulse, dead cycle, gnt 8'h10 again.
- Mid-grant reset and edge cases:
  - While gnt = 8'h40, assert rst 1 cycle -> all outputs zero next cycle.
  - With rr_en = 1 after reset, first grant for req = 8'hC0 is idx 7.
  - Owner release on the same cycle hold_cnt == MAX_HOLD -> no timeout pulse.
